// File: rtl/gpio_pkg.sv
// Shared definitions for GPIO input conditioning: debounce FSM encoding,
// 50 MHz board-clock defaults and the common counter width.
package gpio_pkg;

   localparam int unsigned CNT_W               = 32;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;    // 1 ms at 50 MHz
   localparam int unsigned DEF_HOLDOFF_CYCLES  = 2500000;  // 50 ms at 50 MHz

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      HIGH      = 2'd2,
      REL_CHK   = 2'd3
   } gpio_state_e;

endpackage

// File: rtl/gpio_debounce_trigger_sync2.sv
// Generic two-flop synchronizer for raw GPIO pins; RST_VAL should be the
// de-asserted pin level so reset never fabricates an edge.
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/gpio_debounce_trigger.sv
// Debounces one raw GPIO input into a clean level and a rate-limited one-cycle
// trigger. Optional saturating event counter enabled by GPIO_EVENT_COUNT_EN.
module gpio_debounce_trigger
   import gpio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned COUNT_W         = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               raw_in,
   output logic               level,
   output logic               trigger
`ifdef GPIO_EVENT_COUNT_EN
   ,
   output logic [COUNT_W-1:0] event_count
`endif
);

   gpio_state_e      state_q, state_d;
   logic [CNT_W-1:0] deb_q, deb_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             trig_q, trig_d;
   logic             raw_sync;
   logic             s;

   sync2 #(.RST_VAL(ACTIVE_LOW)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (raw_in),
      .q     (raw_sync)
   );

   assign s = ACTIVE_LOW ? ~raw_sync : raw_sync;

   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      trig_d  = 1'b0;
      // Holdoff runs down independently of the FSM; only an emitted trigger reloads it.
      hold_d  = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
      case (state_q)
         IDLE: begin
            if (s) begin
               deb_d   = CNT_W'(DEBOUNCE_CYCLES - 1);
               state_d = PRESS_CHK;
            end
         end
         PRESS_CHK: begin
            if (!s) begin
               deb_d   = '0;
               state_d = IDLE;
            end else if (deb_q == '0) begin
               state_d = HIGH;
               if (hold_q == '0) begin
                  trig_d = 1'b1;
                  hold_d = CNT_W'(HOLDOFF_CYCLES);
               end
            end else begin
               deb_d = deb_q - 1'b1;
            end
         end
         HIGH: begin
            if (!s) begin
               deb_d   = CNT_W'(DEBOUNCE_CYCLES - 1);
               state_d = REL_CHK;
            end
         end
         REL_CHK: begin
            if (s) begin
               state_d = HIGH;
            end else if (deb_q == '0) begin
               state_d = IDLE;
            end else begin
               deb_d = deb_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         deb_q   <= '0;
         hold_q  <= '0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         hold_q  <= hold_d;
         trig_q  <= trig_d;
      end
   end

   assign level   = (state_q == HIGH) || (state_q == REL_CHK);
   assign trigger = trig_q;

`ifdef GPIO_EVENT_COUNT_EN
   logic [COUNT_W-1:0] evt_q, evt_d;

   always_comb begin
      evt_d = evt_q;
      if (trig_d && (evt_q != '1)) evt_d = evt_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) evt_q <= '0;
      else       evt_q <= evt_d;
   end

   assign event_count = evt_q;
`endif

endmodule

// File: tb/tb_gpio_debounce_trigger.sv
// Bench for gpio_debounce_trigger: two instances (active-high/no holdoff and
// active-low/holdoff 20) driven by one logical press stream and a run-length model.
module tb_gpio_debounce_trigger;

   localparam int D  = 4;
   localparam int HA = 0;
   localparam int HB = 20;

   logic clock = 1'b0;
   logic r, p;
   logic raw_a, raw_b;
   logic level_a, trig_a, level_b, trig_b;
`ifdef GPIO_EVENT_COUNT_EN
   logic [15:0] evt_a;
   logic [1:0]  evt_b;
`endif

   always #5 clock = ~clock;

   assign raw_a = p;
   assign raw_b = ~p;

   gpio_debounce_trigger #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(HA), .ACTIVE_LOW(1'b0), .COUNT_W(16)) dut_a (
      .clock(clock), .reset(r), .raw_in(raw_a), .level(level_a), .trigger(trig_a)
`ifdef GPIO_EVENT_COUNT_EN
      , .event_count(evt_a)
`endif
   );

   gpio_debounce_trigger #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(HB), .ACTIVE_LOW(1'b1), .COUNT_W(2)) dut_b (
      .clock(clock), .reset(r), .raw_in(raw_b), .level(level_b), .trigger(trig_b)
`ifdef GPIO_EVENT_COUNT_EN
      , .event_count(evt_b)
`endif
   );

   // Reference model: pin delayed two samples, level flips once D+1 consecutive
   // samples disagree with it, rising flips fire unless a holdoff timer is running.
   bit m_q1, m_q2, m_level, m_trig_a, m_trig_b;
   int m_run, m_hold_a, m_hold_b, m_cnt_a, m_cnt_b;
   int checks = 0, errors = 0;
   int ntrig_a = 0, ntrig_b = 0;

   function automatic void hold_step(input bit rising, input int hreload, inout int hold,
                                     inout bit trg, inout int cnt, input int cmax);
      trg = rising && (hold == 0);
      if (trg) begin
         hold = hreload;
         if (cnt < cmax) cnt++;
      end else if (hold > 0) begin
         hold--;
      end
   endfunction

   function automatic void model_step();
      bit s, rising;
      if (r) begin
         m_q1 = 0; m_q2 = 0; m_level = 0; m_run = 0;
         m_hold_a = 0; m_hold_b = 0; m_trig_a = 0; m_trig_b = 0;
         m_cnt_a = 0; m_cnt_b = 0;
         return;
      end
      s = m_q2;
      m_q2 = m_q1;
      m_q1 = p;
      rising = 0;
      if (s != m_level) m_run++;
      else m_run = 0;
      if (m_run == D + 1) begin
         m_level = s;
         m_run = 0;
         rising = s;
      end
      hold_step(rising, HA, m_hold_a, m_trig_a, m_cnt_a, 65535);
      hold_step(rising, HB, m_hold_b, m_trig_b, m_cnt_b, 3);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      chk("level_a", 32'(level_a), 32'(m_level));
      chk("trig_a", 32'(trig_a), 32'(m_trig_a));
      chk("level_b", 32'(level_b), 32'(m_level));
      chk("trig_b", 32'(trig_b), 32'(m_trig_b));
`ifdef GPIO_EVENT_COUNT_EN
      chk("evt_a", 32'(evt_a), 32'(m_cnt_a));
      chk("evt_b", 32'(evt_b), 32'(m_cnt_b));
`endif
      if (trig_a === 1'b1) ntrig_a++;
      if (trig_b === 1'b1) ntrig_b++;
   endtask

   // Edges from the first asserted sample to trig_a, bounded.
   task automatic wait_trig(output int k);
      k = 0;
      tick();
      while (trig_a !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
   endtask

   task automatic press(input int n_on, input int n_off);
      p = 1'b1;
      repeat (n_on) tick();
      p = 1'b0;
      repeat (n_off) tick();
   endtask

   typedef struct {
      bit p;
      bit lvl;
      bit trg;
   } vec_t;

   vec_t tbl[20];

   initial begin
      int k, na, nb, lv;
      for (int i = 0; i < 20; i++) begin
         tbl[i].p   = (i + 1 >= 10);
         tbl[i].lvl = (i + 1 >= 16);
         tbl[i].trg = (i + 1 == 16);
      end

      r = 1'b1;
      p = 1'b0;
      tick();
      tick();
      chk("reset_level", 32'(level_a), 0);
      chk("reset_trig", 32'(trig_a), 0);
      r = 1'b0;

      // Rise sampled at edge 10: level/trigger after edge 16, trigger gone after 17.
      for (int i = 0; i < 20; i++) begin
         p = tbl[i].p;
         tick();
         chk("tbl_level", 32'(level_a), 32'(tbl[i].lvl));
         chk("tbl_trig", 32'(trig_a), 32'(tbl[i].trg));
      end

      p = 1'b0;
      repeat (10) tick();
      chk("release_level", 32'(level_a), 0);

      // Three-cycle pulse is rejected.
      na = ntrig_a;
      lv = 0;
      p = 1'b1;
      repeat (3) begin tick(); if (level_a === 1'b1) lv++; end
      p = 1'b0;
      repeat (10) begin tick(); if (level_a === 1'b1) lv++; end
      chk("glitch_trig", 32'(ntrig_a - na), 0);
      chk("glitch_level", 32'(lv), 0);

      // Bounce 1,0,1,1,0 then steady 1: one trigger, 2+D edges after steady start.
      na = ntrig_a;
      p = 1'b1; tick();
      p = 1'b0; tick();
      p = 1'b1; tick(); tick();
      p = 1'b0; tick();
      p = 1'b1;
      wait_trig(k);
      chk("bounce_latency", 32'(k), 32'(2 + D));
      repeat (10) tick();
      chk("bounce_count", 32'(ntrig_a - na), 1);
      p = 1'b0;
      repeat (12) tick();

      // Reset during PRESS_CHK with the input held asserted.
      p = 1'b1;
      repeat (4) tick();
      r = 1'b1;
      tick();
      chk("midreset_level", 32'(level_a), 0);
      chk("midreset_trig", 32'(trig_a), 0);
      r = 1'b0;
      wait_trig(k);
      chk("midreset_latency", 32'(k), 32'(2 + D));
      p = 1'b0;
      repeat (30) tick();

      // Completions every 10 edges: b accepts +0, suppresses +10 and +20 (holdoff 1), accepts +30.
      na = ntrig_a;
      nb = ntrig_b;
      repeat (4) press(5, 5);
      repeat (15) tick();
      chk("holdoff1_a", 32'(ntrig_a - na), 4);
      chk("holdoff1_b", 32'(ntrig_b - nb), 2);
      repeat (30) tick();

      // Completions at +0, +10, +21: holdoff exactly 0 at the third, so accepted.
      na = ntrig_a;
      nb = ntrig_b;
      press(5, 5);
      press(5, 6);
      press(5, 10);
      chk("holdoff2_a", 32'(ntrig_a - na), 3);
      chk("holdoff2_b", 32'(ntrig_b - nb), 2);

      // Random run lengths with occasional reset, checked against the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            r = 1'b1;
            tick();
            r = 1'b0;
         end
         p = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 12)) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_debounce_trigger.md
# gpio_debounce_trigger

Conditions one raw intersection input (car-presence sensor or pedestrian push-button) into a clean, rate-limited single-cycle `trigger` pulse and a debounced `level`. It sits directly upstream of the timed-latch stage. Its `trigger` output drives the latch's trigger input, which then holds the GPIO line seen by QNX for a fixed time. Bounce, glitches and asynchronous sampling are all resolved here, so the latch only ever sees one pulse per genuine press.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: the input must be stable for this many consecutive cycles to change `level`. That is 1 ms at 50 MHz. Legal range is 1 to 2^32-1.
- `HOLDOFF_CYCLES`, default 2500000: minimum spacing between emitted triggers. That is 50 ms at 50 MHz. 0 disables holdoff.
- `ACTIVE_LOW`, default 1: when 1, `raw_in`=0 means asserted, matching board buttons.
- `COUNT_W`, default 16: width of `event_count`.
- `clock`, in, 1: the single clock. All logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `raw_in`, in, 1: asynchronous raw pin.
- `level`, out, 1: debounced, polarity-normalised input state.
- `trigger`, out, 1: one-cycle pulse on each accepted press.
- `event_count`, out, COUNT_W: present only with `GPIO_EVENT_COUNT_EN`.

## Operation
- Two-flop synchronizer on `raw_in`, followed by polarity normalisation. The result `s` is 1 when the input is asserted.
- FSM states:
  - IDLE: `level`=0. When `s`=1, load the debounce counter with DEBOUNCE_CYCLES-1 and go to PRESS_CHK.
  - PRESS_CHK: `level`=0.
    - If `s`=0, return to IDLE and discard the count.
    - Otherwise, when the counter is 0, go to HIGH. Otherwise decrement the counter.
  - HIGH: `level`=1. When `s`=0, load the counter and go to REL_CHK.
  - REL_CHK: `level`=1.
    - If `s`=1, return to HIGH.
    - Otherwise, when the counter is 0, go to IDLE. Otherwise decrement the counter.
- `trigger` fires on the PRESS_CHK→HIGH transition only, and only if the holdoff counter is 0.
  - On emission, the holdoff counter is loaded with HOLDOFF_CYCLES.
  - A press that completes while holdoff is nonzero still sets `level`=1, but emits no trigger.
- The holdoff counter decrements every cycle while nonzero, in every state. It is never reloaded by a suppressed press.
- Counters are 32-bit and unsigned. Comparisons are against 0; there is no wrap because the counters never decrement below 0.
- Releases never emit a trigger.

## Timing
- Reset values: `level`=0, `trigger`=0, `event_count`=0, state IDLE, both counters 0.
- On reset, the synchronizer flops are set to the de-asserted pin value. An input held asserted through reset is therefore treated as a fresh press after reset.
- Press latency: if `raw_in` is stably asserted at edge E, then `s`=1 from edge E+2, and `level` and `trigger` go high after edge E+2+DEBOUNCE_CYCLES.
- `trigger` is high for exactly one cycle.
- Release latency is symmetric: `level` falls after edge E+2+DEBOUNCE_CYCLES.
- Glitch rejection: any `s` sample shorter than DEBOUNCE_CYCLES produces no output change.
- `reset` asserted mid-debounce or mid-holdoff aborts immediately. No pending trigger survives.
- Holdoff boundary:
  - A press completing in the same cycle that holdoff reaches 0 (counter already 0 at that edge) is accepted.
  - If the counter is 1 at that edge, the press is suppressed.

## Configuration
- `GPIO_EVENT_COUNT_EN` defined:
  - Adds the `event_count` port.
  - Increments on every emitted `trigger`.
  - Saturates at all-ones.
  - Cleared only by `reset`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `gpio_pkg`:
  - FSM state encoding (IDLE, PRESS_CHK, HIGH, REL_CHK).
  - Default cycle constants for the 50 MHz board clock (1 ms, 50 ms).
  - The 32-bit counter width constant.
- Sub-module `sync2`:
  - Generic two-flop synchronizer with a reset-value parameter.
  - Reused for every raw GPIO input in the design.

## Test plan
- DEBOUNCE_CYCLES=4, ACTIVE_LOW=0, HOLDOFF_CYCLES=0; `raw_in` rises at edge 10 and stays high → `level` and `trigger` high after edge 16, `trigger` low after edge 17.
- Same config; `raw_in` high for 3 cycles only → `level` and `trigger` stay 0 throughout.
- Bounce sequence 1,0,1,1,0 followed by steady 1 → exactly one `trigger`, 6 cycles after the start of the steady 1 (2 synchronizer + 4 debounce).
- HOLDOFF_CYCLES=20; two clean presses completing 10 cycles apart → first `trigger` emitted, second suppressed with `level`=1. A third press completing 25 cycles after the first → `trigger` emitted.
- `reset` pulsed during PRESS_CHK with the input held asserted → outputs 0, then `trigger` emitted 2+4 cycles after `reset` drops.
- With `GPIO_EVENT_COUNT_EN`, COUNT_W=2, 5 accepted presses → `event_count` reads 1, 2, 3, 3, 3.
